// File: rtl/alu_stack_sequencer.sv
// Operand/command sequencer for the ALU: owns a hardware operand stack, accepts stack commands,
// drives the ALU load strobes/bus/opcode and writes the ALU result back onto the stack.
module alu_stack_sequencer #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int ALU_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [1:0]    cmd_kind_i,
    input  logic [3:0]    cmd_op_i,
    input  logic [15:0]   cmd_data_i,
    output logic          alu_a_ld_o,
    output logic          alu_b_ld_o,
    output logic          alu_c_ld_o,
    output logic [15:0]   alu_bus_o,
    input  logic [15:0]   alu_result_i,
    output logic [15:0]   top_data_o,
    output logic [AW:0]   depth_o,
    output logic          busy_o,
    output logic          err_underflow_o,
    output logic          err_overflow_o,
    output logic          err_illegal_o
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [1:0] K_PUSH  = 2'b00;
    localparam logic [1:0] K_POP   = 2'b01;
    localparam logic [1:0] K_ALU   = 2'b10;
    localparam logic [1:0] K_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDB  = 3'd1,
        S_LDA  = 3'd2,
        S_LDC  = 3'd3,
        S_WAIT = 3'd4,
        S_WB   = 3'd5
    } state_e;

    function automatic logic op_is_unary(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b1001) || (op == 4'b1011);
    endfunction

    function automatic logic op_is_illegal(input logic [3:0] op);
        return (op[3:2] == 2'b11);
    endfunction

    state_e         state_q;
    logic           cmd_ready_q;
    logic           a_ld_q;
    logic           b_ld_q;
    logic           c_ld_q;
    logic [15:0]    bus_q;
    logic [15:0]    top_q;
    logic [AW:0]    depth_q;
    logic           busy_q;
    logic           err_un_q;
    logic           err_ov_q;
    logic           err_ill_q;
    logic [3:0]     op_q;
    logic           unary_q;
    logic [CW-1:0]  wait_cnt_q;

    // Stack storage is deliberately not reset; depth alone defines which entries are live.
    logic [15:0]    stack_q [DEPTH];

    logic           accept_s;
    logic           full_s;
    logic           empty_s;
    logic [AW-1:0]  top_idx_s;
    logic [AW-1:0]  sec_idx_s;
    logic           new_unary_s;
    logic           enough_s;
    logic           wr_en_s;
    logic [AW-1:0]  wr_idx_s;
    logic [15:0]    wr_data_s;

    assign accept_s    = cmd_valid_i & cmd_ready_q;
    assign full_s      = (depth_q == (AW+1)'(DEPTH));
    assign empty_s     = (depth_q == {(AW+1){1'b0}});
    assign top_idx_s   = depth_q[AW-1:0] - AW'(1);
    assign sec_idx_s   = depth_q[AW-1:0] - AW'(2);
    assign new_unary_s = op_is_unary(cmd_op_i);
    assign enough_s    = new_unary_s ? (depth_q >= (AW+1)'(1)) : (depth_q >= (AW+1)'(2));

    // Stack write port: a PUSH on accept, or the ALU result during write-back.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = depth_q[AW-1:0];
        wr_data_s = cmd_data_i;
        if (state_q == S_IDLE && accept_s && cmd_kind_i == K_PUSH && !full_s) begin
            wr_en_s = 1'b1;
        end else if (state_q == S_WB) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = unary_q ? top_idx_s : sec_idx_s;
            wr_data_s = alu_result_i;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Stack RAM write.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            stack_q[wr_idx_s] <= wr_data_s;
        end
    end

    // Sequencer FSM with registered strobes, bus, status and sticky error flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            a_ld_q      <= 1'b0;
            b_ld_q      <= 1'b0;
            c_ld_q      <= 1'b0;
            bus_q       <= 16'h0000;
            top_q       <= 16'h0000;
            depth_q     <= {(AW+1){1'b0}};
            busy_q      <= 1'b0;
            err_un_q    <= 1'b0;
            err_ov_q    <= 1'b0;
            err_ill_q   <= 1'b0;
            op_q        <= 4'h0;
            unary_q     <= 1'b0;
            wait_cnt_q  <= {CW{1'b0}};
        end else begin
            a_ld_q <= 1'b0;
            b_ld_q <= 1'b0;
            c_ld_q <= 1'b0;
            bus_q  <= 16'h0000;
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        case (cmd_kind_i)
                            K_PUSH: begin
                                if (full_s) begin
                                    err_ov_q <= 1'b1;
                                end else begin
                                    depth_q <= depth_q + (AW+1)'(1);
                                    top_q   <= cmd_data_i;
                                end
                            end
                            K_POP: begin
                                if (empty_s) begin
                                    err_un_q <= 1'b1;
                                end else begin
                                    depth_q <= depth_q - (AW+1)'(1);
                                    top_q   <= (depth_q >= (AW+1)'(2)) ? stack_q[sec_idx_s] : 16'h0000;
                                end
                            end
                            K_ALU: begin
                                if (op_is_illegal(cmd_op_i)) begin
                                    err_ill_q <= 1'b1;
                                end else if (!enough_s) begin
                                    err_un_q <= 1'b1;
                                end else begin
                                    // The top entry is the first operand on the bus either way:
                                    // b for binary ops, a for unary ops.
                                    op_q        <= cmd_op_i;
                                    unary_q     <= new_unary_s;
                                    busy_q      <= 1'b1;
                                    cmd_ready_q <= 1'b0;
                                    bus_q       <= stack_q[top_idx_s];
                                    if (new_unary_s) begin
                                        state_q <= S_LDA;
                                        a_ld_q  <= 1'b1;
                                    end else begin
                                        state_q <= S_LDB;
                                        b_ld_q  <= 1'b1;
                                    end
                                end
                            end
                            K_CLEAR: begin
                                depth_q <= {(AW+1){1'b0}};
                                top_q   <= 16'h0000;
                            end
                            default: begin
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_LDB: begin
                    state_q <= S_LDA;
                    a_ld_q  <= 1'b1;
                    bus_q   <= stack_q[sec_idx_s];
                end
                S_LDA: begin
                    state_q <= S_LDC;
                    c_ld_q  <= 1'b1;
                    bus_q   <= {12'h000, op_q};
                end
                S_LDC: begin
                    state_q    <= S_WAIT;
                    wait_cnt_q <= CW'(ALU_LAT - 1);
                end
                S_WAIT: begin
                    if (wait_cnt_q == {CW{1'b0}}) begin
                        state_q <= S_WB;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CW'(1);
                    end
                end
                S_WB: begin
                    // Binary ops consume two entries and produce one; unary ops overwrite the top.
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    top_q       <= alu_result_i;
                    if (!unary_q) begin
                        depth_q <= depth_q - (AW+1)'(1);
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o     = cmd_ready_q;
    assign alu_a_ld_o      = a_ld_q;
    assign alu_b_ld_o      = b_ld_q;
    assign alu_c_ld_o      = c_ld_q;
    assign alu_bus_o       = bus_q;
    assign top_data_o      = top_q;
    assign depth_o         = depth_q;
    assign busy_o          = busy_q;
    assign err_underflow_o = err_un_q;
    assign err_overflow_o  = err_ov_q;
    assign err_illegal_o   = err_ill_q;

endmodule
